// File: rtl/sc_matrix_scan_if.sv
// Bus bundle between the row generators, the matrix scanner and the LED driver:
// eight row buses in, one row-select/column pair plus frame strobe out.
interface sc_matrix_scan_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic                     SC_MATRIX_SCAN_ENABLE;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_0_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_1_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_2_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_3_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_4_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_5_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_6_IN;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_ROW_7_IN;
    logic [7:0]               SC_MATRIX_SCAN_ROW_SEL;
    logic [DATAWIDTH_BUS-1:0] SC_MATRIX_SCAN_COL_OUT;
    logic                     SC_MATRIX_SCAN_FRAME_DONE;

    modport master (
        output SC_MATRIX_SCAN_ENABLE,
        output SC_MATRIX_SCAN_ROW_0_IN, SC_MATRIX_SCAN_ROW_1_IN,
        output SC_MATRIX_SCAN_ROW_2_IN, SC_MATRIX_SCAN_ROW_3_IN,
        output SC_MATRIX_SCAN_ROW_4_IN, SC_MATRIX_SCAN_ROW_5_IN,
        output SC_MATRIX_SCAN_ROW_6_IN, SC_MATRIX_SCAN_ROW_7_IN,
        input  SC_MATRIX_SCAN_ROW_SEL, SC_MATRIX_SCAN_COL_OUT,
        input  SC_MATRIX_SCAN_FRAME_DONE
    );

    modport slave (
        input  SC_MATRIX_SCAN_ENABLE,
        input  SC_MATRIX_SCAN_ROW_0_IN, SC_MATRIX_SCAN_ROW_1_IN,
        input  SC_MATRIX_SCAN_ROW_2_IN, SC_MATRIX_SCAN_ROW_3_IN,
        input  SC_MATRIX_SCAN_ROW_4_IN, SC_MATRIX_SCAN_ROW_5_IN,
        input  SC_MATRIX_SCAN_ROW_6_IN, SC_MATRIX_SCAN_ROW_7_IN,
        output SC_MATRIX_SCAN_ROW_SEL, SC_MATRIX_SCAN_COL_OUT,
        output SC_MATRIX_SCAN_FRAME_DONE
    );
endinterface

// File: rtl/sc_matrix_scan.sv
// Time-multiplexes a captured 8x8 frame onto one-hot row select and column bus,
// with a one-cycle blank between rows to suppress ghosting.
module sc_matrix_scan #(
    parameter int DATAWIDTH_BUS   = 8,
    parameter int PRESCALER       = 50000,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic          SC_MATRIX_SCAN_CLOCK_50,
    input  logic          SC_MATRIX_SCAN_RESET,
    sc_matrix_scan_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} state_t;

    localparam logic [PRESCALER_WIDTH-1:0] DWELL_LAST = PRESCALER_WIDTH'(PRESCALER - 1);

    state_t                     state_q, state_d;
    logic [2:0]                 rowIdx_q, rowIdx_d;
    logic [PRESCALER_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATAWIDTH_BUS-1:0]   buf_q [8];
    logic [DATAWIDTH_BUS-1:0]   buf_d [8];
    logic                       armed_q;
    logic [DATAWIDTH_BUS-1:0]   rowIn [8];

    assign rowIn[0] = bus.SC_MATRIX_SCAN_ROW_0_IN;
    assign rowIn[1] = bus.SC_MATRIX_SCAN_ROW_1_IN;
    assign rowIn[2] = bus.SC_MATRIX_SCAN_ROW_2_IN;
    assign rowIn[3] = bus.SC_MATRIX_SCAN_ROW_3_IN;
    assign rowIn[4] = bus.SC_MATRIX_SCAN_ROW_4_IN;
    assign rowIn[5] = bus.SC_MATRIX_SCAN_ROW_5_IN;
    assign rowIn[6] = bus.SC_MATRIX_SCAN_ROW_6_IN;
    assign rowIn[7] = bus.SC_MATRIX_SCAN_ROW_7_IN;

    // armed_q holds the FSM in IDLE for the first edge after reset release,
    // so a release close to an edge can never start a frame on that edge.
    always_ff @(posedge SC_MATRIX_SCAN_CLOCK_50 or negedge SC_MATRIX_SCAN_RESET) begin
        if (!SC_MATRIX_SCAN_RESET) begin
            state_q  <= IDLE;
            rowIdx_q <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rowIdx_q <= rowIdx_d;
            cnt_q    <= cnt_d;
            armed_q  <= 1'b1;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rowIdx_d = rowIdx_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        case (state_q)
            IDLE: begin
                if (bus.SC_MATRIX_SCAN_ENABLE && armed_q) state_d = LOAD;
            end
            LOAD: begin
                buf_d    = rowIn;
                rowIdx_d = '0;
                cnt_d    = '0;
                state_d  = SCAN;
            end
            SCAN: begin
                cnt_d = cnt_q + PRESCALER_WIDTH'(1);
                if (cnt_q == DWELL_LAST) state_d = BLANK;
            end
            BLANK: begin
                cnt_d = '0;
                if (rowIdx_q != 3'd7) begin
                    rowIdx_d = rowIdx_q + 3'd1;
                    state_d  = SCAN;
                end else begin
                    state_d = bus.SC_MATRIX_SCAN_ENABLE ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    always_comb begin
        bus.SC_MATRIX_SCAN_ROW_SEL    = '0;
        bus.SC_MATRIX_SCAN_COL_OUT    = '0;
        bus.SC_MATRIX_SCAN_FRAME_DONE = 1'b0;
        if (state_q == SCAN) begin
            bus.SC_MATRIX_SCAN_ROW_SEL = 8'h01 << rowIdx_q;
            bus.SC_MATRIX_SCAN_COL_OUT = buf_q[rowIdx_q];
        end
        if (state_q == BLANK && rowIdx_q == 3'd7) bus.SC_MATRIX_SCAN_FRAME_DONE = 1'b1;
    end

endmodule

// File: tb/tb_sc_matrix_scan.sv
// Scoreboard bench for sc_matrix_scan with PRESCALER=4 (41-cycle frames):
// stimulus queues the expected outputs per cycle, a negedge monitor checks them.
module tb_sc_matrix_scan;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] col;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sbq [$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   cycleNo     = 0;

    logic [7:0] rowsA [8];
    logic [7:0] rowsB [8];
    logic [7:0] rowsC [8];
    logic [7:0] rowsD [8];
    logic [7:0] rowsE [8];
    logic [7:0] nextRows [8];

    sc_matrix_scan_if #(.DATAWIDTH_BUS(8)) bus ();

    sc_matrix_scan #(
        .DATAWIDTH_BUS  (8),
        .PRESCALER      (4),
        .PRESCALER_WIDTH(16)
    ) dut (
        .SC_MATRIX_SCAN_CLOCK_50(clk),
        .SC_MATRIX_SCAN_RESET   (rst_n),
        .bus                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveRows(input logic [7:0] v [8]);
        bus.SC_MATRIX_SCAN_ROW_0_IN = v[0];
        bus.SC_MATRIX_SCAN_ROW_1_IN = v[1];
        bus.SC_MATRIX_SCAN_ROW_2_IN = v[2];
        bus.SC_MATRIX_SCAN_ROW_3_IN = v[3];
        bus.SC_MATRIX_SCAN_ROW_4_IN = v[4];
        bus.SC_MATRIX_SCAN_ROW_5_IN = v[5];
        bus.SC_MATRIX_SCAN_ROW_6_IN = v[6];
        bus.SC_MATRIX_SCAN_ROW_7_IN = v[7];
    endtask

    // One clock cycle: advance past the edge, optionally pull reset mid-cycle,
    // and queue what the outputs must show for the rest of this cycle.
    task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] col,
                                 input logic done, input bit rstLow);
        exp_t e;
        @(posedge clk);
        #1;
        if (rstLow) rst_n = 1'b0;
        e.sel  = sel;
        e.col  = col;
        e.done = done;
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s cycle %0d: got sel=%h col=%h done=%b, required sel=%h col=%h done=%b",
                     name, cycleNo, act[16:9], act[8:1], act[0], req[16:9], req[8:1], req[0]);
        end
    endtask

    // Full frame starting with its LOAD cycle; optional mid-frame events.
    task automatic expectFrame(input logic [7:0] fr [8], input int chgRow,
                               input int dropRow, input int abortRow);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (r == abortRow && k == 1) begin
                    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
                    return;
                end
                applyStimulus(8'h01 << r, fr[r], 1'b0, 1'b0);
                if (k == 0 && r == chgRow) driveRows(nextRows);
                if (k == 0 && r == dropRow) bus.SC_MATRIX_SCAN_ENABLE = 1'b0;
            end
            applyStimulus(8'h00, 8'h00, (r == 7), 1'b0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cycleNo++;
        nCompared++;
        if ($countones(bus.SC_MATRIX_SCAN_ROW_SEL) > 1) begin
            nMismatched++;
            $display("[TB] FAIL onehot cycle %0d: got ROW_SEL=%h, required at most one bit set",
                     cycleNo, bus.SC_MATRIX_SCAN_ROW_SEL);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("outputs",
                        {bus.SC_MATRIX_SCAN_ROW_SEL, bus.SC_MATRIX_SCAN_COL_OUT, bus.SC_MATRIX_SCAN_FRAME_DONE},
                        {e.sel, e.col, e.done});
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required completion within 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rowsA = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        rowsB = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        rowsC = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
        rowsD = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h12, 8'h34, 8'h56, 8'h78};
        rowsE = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

        rst_n = 1'b0;
        bus.SC_MATRIX_SCAN_ENABLE = 1'b0;
        driveRows(rowsA);

        // Reset held with random inputs: everything stays dark.
        repeat (5) begin
            applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
            bus.SC_MATRIX_SCAN_ENABLE = 1'($urandom_range(1));
            for (int i = 0; i < 8; i++) nextRows[i] = 8'($urandom);
            driveRows(nextRows);
        end
        rst_n = 1'b1;
        bus.SC_MATRIX_SCAN_ENABLE = 1'b0;
        repeat (4) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

        // Three back-to-back frames; row 0 changes mid-frame A, new pattern mid-frame B,
        // enable dropped in row 3 of frame C.
        driveRows(rowsA);
        bus.SC_MATRIX_SCAN_ENABLE = 1'b1;
        nextRows = rowsB;
        expectFrame(rowsA, 2, -1, -1);
        nextRows = rowsC;
        expectFrame(rowsB, 4, -1, -1);
        expectFrame(rowsC, -1, 3, -1);
        repeat (5) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset during row 5, then restart with fresh data after release.
        driveRows(rowsD);
        bus.SC_MATRIX_SCAN_ENABLE = 1'b1;
        expectFrame(rowsD, -1, -1, 5);
        driveRows(rowsE);
        repeat (3) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        expectFrame(rowsE, -1, 0, -1);
        repeat (3) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL drain: got %0d unchecked entries, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sc_matrix_scan.md
SC_MATRIX_SCAN -- requirements
Module: sc_matrix_scan

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATAWIDTH_BUS, 8, width of each row bus and of column output.
- PRESCALER, 50000, clock cycles each row is driven (dwell); minimum 2.
- PRESCALER_WIDTH, 16, width of dwell counter; must hold PRESCALER-1.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- SC_MATRIX_SCAN_CLOCK_50  in  1  single system clock, rising-edge.
- SC_MATRIX_SCAN_RESET  in  1  asynchronous reset, active-low.
- SC_MATRIX_SCAN_ENABLE  in  1  level; 1 = keep scanning frames.
- SC_MATRIX_SCAN_ROW_7_IN .. SC_MATRIX_SCAN_ROW_0_IN  in  8 each  matrix rows from the frog/lane generators, bit x = column x.
- SC_MATRIX_SCAN_ROW_SEL  out  8  one-hot row drive, bit r = row r active; all-zero = blank.
- SC_MATRIX_SCAN_COL_OUT  out  8  column data for selected row.
- SC_MATRIX_SCAN_FRAME_DONE  out  1  one-cycle pulse at end of each frame.

REQ-003 One clock domain, no internal clock gating or derived clocks.

Function
REQ-004 Block SHALL be the display-side consumer of the 8x8 row buses, time-multiplexing them onto one row-select and one column bus.
REQ-005 FSM states SHALL be IDLE, LOAD, SCAN, BLANK.
REQ-006 IDLE: ROW_SEL=0, COL_OUT=0, FRAME_DONE=0; ENABLE=1 at an edge -> LOAD, else stay.
REQ-007 LOAD: exactly one cycle; on the edge leaving LOAD, all 8 row inputs SHALL be captured into an internal 8x8 frame buffer, row index set to 0, dwell counter cleared, next state SCAN; outputs blank during LOAD.
REQ-008 SCAN: ROW_SEL = one-hot(row index), COL_OUT = buffer[row index]; dwell counter increments each cycle; at count PRESCALER-1 -> BLANK, so SCAN lasts exactly PRESCALER cycles.
REQ-009 BLANK: exactly one cycle, ROW_SEL=0, COL_OUT=0 (anti-ghosting).
REQ-010 BLANK with row index < 7: row index +1, counter cleared, -> SCAN.
REQ-011 BLANK with row index = 7: FRAME_DONE=1 this cycle only; ENABLE=1 -> LOAD, ENABLE=0 -> IDLE.
REQ-012 Frame period SHALL be 1 + 8*(PRESCALER+1) cycles; continuous ENABLE gives back-to-back frames with no extra idle cycle.
REQ-013 Outputs SHALL be Moore functions of registered state, row index and buffer; no combinational path from any input to any output.
REQ-014 Row input changes outside the LOAD capture edge SHALL NOT affect outputs until the next frame.
REQ-015 ENABLE deasserted mid-frame SHALL NOT abort; frame completes through row 7 BLANK, then IDLE.
REQ-016 ROW_SEL SHALL never have more than one bit set in any cycle.
REQ-017 Row index SHALL NOT wrap from 7 to 0 inside a frame; restart only via LOAD.

Reset
REQ-018 RESET=0 SHALL immediately, without waiting for a clock edge, force state IDLE, row index 0, counter 0, buffer all-zero, ROW_SEL=0, COL_OUT=0, FRAME_DONE=0.
REQ-019 Reset asserted mid-frame SHALL discard the frame; after release, scanning restarts only via IDLE -> LOAD.
REQ-020 Reset release SHALL be synchronous-safe; first state change no earlier than the second rising edge after release.

Verification (PRESCALER=4, frame = 41 cycles)
REQ-021 Reset low with random inputs -> ROW_SEL=8'h00, COL_OUT=8'h00, FRAME_DONE=0 throughout; hold after release with ENABLE=0.
REQ-022 ROW_0_IN=8'h01, ROW_7_IN=8'h80, others 8'h00, ENABLE=1 -> LOAD 1 cycle; ROW_SEL=8'h01/COL_OUT=8'h01 for 4 cycles; 1 blank cycle; ROW_SEL=8'h02/COL_OUT=8'h00 for 4; ... ROW_SEL=8'h80/COL_OUT=8'h80 for 4; FRAME_DONE pulse at frame cycle 41.
REQ-023 Change ROW_0_IN to 8'hFF during row 2 SCAN -> current frame unaffected; next frame row 0 shows COL_OUT=8'hFF.
REQ-024 ENABLE dropped during row 3 -> rows 3..7 complete, one FRAME_DONE pulse, then IDLE with all outputs 8'h00.
REQ-025 RESET low during row 5 SCAN (asynchronous to clock) -> outputs 8'h00 within the same cycle; after release with ENABLE=1, next frame starts at row 0 with freshly captured data.
REQ-026 ENABLE held high for 3 frames -> FRAME_DONE exactly every 41 cycles, LOAD immediately follows each row-7 BLANK, one-hot ROW_SEL checked every cycle.
